sys_mem_arb: RTL

Two-client arbiter placed between the cortex system-memory master ports and the SDRAM controller interface (`mem_wait` / `mem_wren` / `mem_rden` / `mem_addr` / `mem_wdata` / `mem_rd_valid` / `mem_rdata`). It gives round-robin access to one controller port and registers the command stage. A tag FIFO tracks every outstanding read so that returned read data goes back to the client that issued it.

---
 rtl/sys_mem_arb.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sys_mem_arb.sv
// sys_mem_arb
// Round-robin arbiter that puts two system-memory clients onto one SDRAM
// controller port. The command stage is registered. A tag FIFO holds the
// client id of every outstanding read, so returned data goes back to the
// client that issued the read.
//
// Ports:
//   clk, rst_n            controller clock, async active-low reset
//   clN_wren/rden/addr/   client N request (a write wins over a read)
//   clN_wdata
//   clN_rdy               request accepted this cycle (combinational)
//   clN_rd_valid/rdata    routed read return, one cycle after mem_rd_valid
//   mem_wait              controller stall; a pending command is held
//   mem_wren/rden/addr/   registered command to the controller
//   mem_wdata
//   mem_rd_valid/rdata    controller read return
//   rsp_err               sticky: read data returned with no read outstanding
module sys_mem_arb #(
  parameter int SYS_MEM_DATA_W = 32,
  parameter int SYS_MEM_ADDR_W = 27,
  parameter int RD_FIFO_DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cl0_wren,
  input  logic                      cl0_rden,
  input  logic [SYS_MEM_ADDR_W-1:0] cl0_addr,
  input  logic [SYS_MEM_DATA_W-1:0] cl0_wdata,
  output logic                      cl0_rdy,
  output logic                      cl0_rd_valid,
  output logic [SYS_MEM_DATA_W-1:0] cl0_rdata,
  input  logic                      cl1_wren,
  input  logic                      cl1_rden,
  input  logic [SYS_MEM_ADDR_W-1:0] cl1_addr,
  input  logic [SYS_MEM_DATA_W-1:0] cl1_wdata,
  output logic                      cl1_rdy,
  output logic                      cl1_rd_valid,
  output logic [SYS_MEM_DATA_W-1:0] cl1_rdata,
  input  logic                      mem_wait,
  output logic                      mem_wren,
  output logic                      mem_rden,
  output logic [SYS_MEM_ADDR_W-1:0] mem_addr,
  output logic [SYS_MEM_DATA_W-1:0] mem_wdata,
  input  logic                      mem_rd_valid,
  input  logic [SYS_MEM_DATA_W-1:0] mem_rdata,
  output logic                      rsp_err
);

  localparam int PW = $clog2(RD_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RD_FIFO_DEPTH);

  logic [CW-1:0] rd_count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          tag_mem [RD_FIFO_DEPTH];
  logic          last_gnt;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      adv;
  logic                      elig0;
  logic                      elig1;
  logic                      gnt_valid;
  logic                      gnt_id;
  logic                      accept;
  logic                      gnt_wr;
  logic                      gnt_rd;
  logic [SYS_MEM_ADDR_W-1:0] gnt_addr;
  logic [SYS_MEM_DATA_W-1:0] gnt_wdata;
  logic                      push;
  logic                      pop;
  logic                      head_id;

  always_comb begin
    fifo_full  = (rd_count == FULL_CNT);
    fifo_empty = (rd_count == '0);
    adv        = ~(mem_wren | mem_rden) | ~mem_wait;
    // Reads are gated on the start-of-cycle count, so a pop in this cycle
    // does not open a slot until the next one.
    elig0      = cl0_wren | (cl0_rden & ~fifo_full);
    elig1      = cl1_wren | (cl1_rden & ~fifo_full);
    gnt_valid  = elig0 | elig1;
    gnt_id     = (elig0 & elig1) ? ~last_gnt : elig1;
    accept     = adv & gnt_valid;
    gnt_wr     = gnt_id ? cl1_wren : cl0_wren;
    gnt_rd     = ~gnt_wr & (gnt_id ? cl1_rden : cl0_rden);
    gnt_addr   = gnt_id ? cl1_addr : cl0_addr;
    gnt_wdata  = gnt_id ? cl1_wdata : cl0_wdata;
    push       = accept & gnt_rd;
    pop        = mem_rd_valid & ~fifo_empty;
    head_id    = tag_mem[rd_ptr];
  end

  assign cl0_rdy = accept & ~gnt_id;
  assign cl1_rdy = accept & gnt_id;

  // Command stage and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wren  <= 1'b0;
      mem_rden  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_gnt  <= 1'b1;
    end else if (adv) begin
      if (accept) begin
        mem_wren  <= gnt_wr;
        mem_rden  <= gnt_rd;
        mem_addr  <= gnt_addr;
        mem_wdata <= gnt_wdata;
        last_gnt  <= gnt_id;
      end else begin
        mem_wren <= 1'b0;
        mem_rden <= 1'b0;
      end
    end
  end

  // Tag FIFO control; pointers wrap naturally as the depth is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   rd_count <= rd_count + CW'(1);
        2'b01:   rd_count <= rd_count - CW'(1);
        default: rd_count <= rd_count;
      endcase
    end
  end

  // Tag storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= gnt_id;
  end

  // Read return routing and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cl0_rd_valid <= 1'b0;
      cl1_rd_valid <= 1'b0;
      cl0_rdata    <= '0;
      cl1_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      cl0_rd_valid <= pop & ~head_id;
      cl1_rd_valid <= pop & head_id;
      if (pop & ~head_id) cl0_rdata <= mem_rdata;
      if (pop & head_id)  cl1_rdata <= mem_rdata;
      if (mem_rd_valid & fifo_empty) rsp_err <= 1'b1;
    end
  end

endmodule
